// File: rtl/msi_snoop_cluster.sv
// msi_snoop_cluster: NPROC private direct-mapped caches kept coherent with MSI
// over one serialised snooping bus, backed by a shared word-addressed memory.
// One request is in flight at a time; the bus FSM walks it through lookup,
// optional victim eviction, snoop, optional remote write-back, fill and response.
module msi_snoop_cluster #(
    parameter int NPROC  = 3,
    parameter int LINES  = 4,
    parameter int ADDR_W = 4,
    parameter int DW     = 4,
    localparam int PID_W = ($clog2(NPROC) < 1) ? 1 : $clog2(NPROC),
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = ADDR_W - IDX_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PID_W-1:0]  req_proc,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_data,
    output logic              resp_hit,
    output logic              resp_err,
    output logic [1:0]        resp_prev,
    output logic [1:0]        resp_new,
    output logic [1:0]        bus_op,
    output logic [7:0]        wb_count,
    input  logic [PID_W-1:0]  q_proc,
    input  logic [ADDR_W-1:0] q_addr,
    output logic [1:0]        q_state
);

    localparam int MEM_D = 1 << ADDR_W;
    localparam logic [PID_W:0] NPROC_L = (PID_W+1)'(NPROC);
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd0, OP_RD = 2'd1, OP_RDX = 2'd2, OP_UPGR = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        EVICT  = 3'd2,
        SNOOP  = 3'd3,
        WB     = 3'd4,
        FILL   = 3'd5,
        RESP   = 3'd6
    } fsm_e;

    fsm_e              state_q;
    logic [1:0]        st_q   [NPROC][LINES];
    logic [TAG_W-1:0]  tag_q  [NPROC][LINES];
    logic [DW-1:0]     data_q [NPROC][LINES];
    logic [DW-1:0]     mem_q  [MEM_D];

    logic [PID_W-1:0]  proc_q, holder_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     wdata_q;
    logic [1:0]        op_q;

    logic              resp_valid_q, resp_hit_q, resp_err_q;
    logic [DW-1:0]     resp_data_q;
    logic [1:0]        resp_prev_q, resp_new_q, bus_op_q;
    logic [7:0]        wb_cnt_q;

    logic              req_ok_s, hit_s, dirty_victim_s, rm_found_s;
    logic [PID_W-1:0]  pid_s, rm_pid_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s, loc_tag_s;
    logic [1:0]        loc_st_s;
    logic [DW-1:0]     loc_data_s;

    logic              q_ok_s;
    logic [PID_W-1:0]  q_pid_s;
    logic [IDX_W-1:0]  q_idx_s;
    logic [1:0]        q_state_s;

    // Decode the captured request against the requester's own cache line
    always_comb begin
        idx_s    = addr_q[IDX_W-1:0];
        tag_s    = addr_q[ADDR_W-1:IDX_W];
        req_ok_s = ({1'b0, proc_q} < NPROC_L);
        if (req_ok_s) begin
            pid_s = proc_q;
        end else begin
            pid_s = '0;
        end
        loc_st_s       = st_q[pid_s][idx_s];
        loc_tag_s      = tag_q[pid_s][idx_s];
        loc_data_s     = data_q[pid_s][idx_s];
        hit_s          = req_ok_s && (loc_st_s != ST_I) && (loc_tag_s == tag_s);
        dirty_victim_s = (loc_st_s == ST_M) && (loc_tag_s != tag_s);
    end

    // Find a remote cache holding the requested address in M
    always_comb begin
        rm_found_s = 1'b0;
        rm_pid_s   = '0;
        for (int p = 0; p < NPROC; p++) begin
            if ((PID_W'(p) != pid_s) && (st_q[p][idx_s] == ST_M) && (tag_q[p][idx_s] == tag_s)) begin
                rm_found_s = 1'b1;
                rm_pid_s   = PID_W'(p);
            end else begin
                rm_found_s = rm_found_s;
            end
        end
    end

    // Status query for the display side; out-of-range processors read as I
    always_comb begin
        q_ok_s  = ({1'b0, q_proc} < NPROC_L);
        q_idx_s = q_addr[IDX_W-1:0];
        if (q_ok_s) begin
            q_pid_s = q_proc;
        end else begin
            q_pid_s = '0;
        end
        if (q_ok_s && (st_q[q_pid_s][q_idx_s] != ST_I) &&
            (tag_q[q_pid_s][q_idx_s] == q_addr[ADDR_W-1:IDX_W])) begin
            q_state_s = st_q[q_pid_s][q_idx_s];
        end else begin
            q_state_s = ST_I;
        end
    end

    // Bus FSM: owns the cache arrays, the memory and every registered response field
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            for (int p = 0; p < NPROC; p++) begin
                for (int l = 0; l < LINES; l++) begin
                    st_q[p][l]   <= ST_I;
                    tag_q[p][l]  <= '0;
                    data_q[p][l] <= '0;
                end
            end
            for (int k = 0; k < MEM_D; k++) begin
                mem_q[k] <= DW'(k);
            end
            proc_q       <= '0;
            holder_q     <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= OP_NONE;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_prev_q  <= ST_I;
            resp_new_q   <= ST_I;
            bus_op_q     <= OP_NONE;
            wb_cnt_q     <= 8'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        proc_q  <= req_proc;
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!req_ok_s) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                        resp_hit_q   <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_prev_q  <= ST_I;
                        resp_new_q   <= ST_I;
                        bus_op_q     <= OP_NONE;
                        state_q      <= RESP;
                    end else if (hit_s && (!write_q || (loc_st_s == ST_M))) begin
                        if (write_q) begin
                            data_q[pid_s][idx_s] <= wdata_q;
                        end
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= write_q ? wdata_q : loc_data_s;
                        resp_hit_q   <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_prev_q  <= loc_st_s;
                        resp_new_q   <= loc_st_s;
                        bus_op_q     <= OP_NONE;
                        state_q      <= RESP;
                    end else if (hit_s) begin
                        op_q    <= OP_UPGR;
                        state_q <= SNOOP;
                    end else begin
                        op_q    <= write_q ? OP_RDX : OP_RD;
                        state_q <= dirty_victim_s ? EVICT : SNOOP;
                    end
                end
                EVICT: begin
                    mem_q[{loc_tag_s, idx_s}] <= loc_data_s;
                    st_q[pid_s][idx_s]        <= ST_I;
                    wb_cnt_q                  <= wb_cnt_q + 8'd1;
                    state_q                   <= SNOOP;
                end
                SNOOP: begin
                    // BusRdX and BusUpgr both strip every remote shared copy
                    if (op_q != OP_RD) begin
                        for (int p = 0; p < NPROC; p++) begin
                            if ((PID_W'(p) != pid_s) && (st_q[p][idx_s] == ST_S) && (tag_q[p][idx_s] == tag_s)) begin
                                st_q[p][idx_s] <= ST_I;
                            end
                        end
                    end
                    if (op_q == OP_UPGR) begin
                        st_q[pid_s][idx_s]   <= ST_M;
                        data_q[pid_s][idx_s] <= wdata_q;
                        resp_valid_q         <= 1'b1;
                        resp_data_q          <= wdata_q;
                        resp_hit_q           <= 1'b1;
                        resp_err_q           <= 1'b0;
                        resp_prev_q          <= ST_S;
                        resp_new_q           <= ST_M;
                        bus_op_q             <= OP_UPGR;
                        state_q              <= RESP;
                    end else if (rm_found_s) begin
                        holder_q <= rm_pid_s;
                        state_q  <= WB;
                    end else begin
                        state_q <= FILL;
                    end
                end
                WB: begin
                    mem_q[addr_q]            <= data_q[holder_q][idx_s];
                    st_q[holder_q][idx_s]    <= write_q ? ST_I : ST_S;
                    wb_cnt_q                 <= wb_cnt_q + 8'd1;
                    state_q                  <= FILL;
                end
                FILL: begin
                    st_q[pid_s][idx_s]   <= write_q ? ST_M : ST_S;
                    tag_q[pid_s][idx_s]  <= tag_s;
                    data_q[pid_s][idx_s] <= write_q ? wdata_q : mem_q[addr_q];
                    resp_valid_q         <= 1'b1;
                    resp_data_q          <= write_q ? wdata_q : mem_q[addr_q];
                    resp_hit_q           <= 1'b0;
                    resp_err_q           <= 1'b0;
                    resp_prev_q          <= ST_I;
                    resp_new_q           <= write_q ? ST_M : ST_S;
                    bus_op_q             <= op_q;
                    state_q              <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_hit   = resp_hit_q;
    assign resp_err   = resp_err_q;
    assign resp_prev  = resp_prev_q;
    assign resp_new   = resp_new_q;
    assign bus_op     = bus_op_q;
    assign wb_count   = wb_cnt_q;
    assign q_state    = q_state_s;

endmodule

// File: tb/tb_msi_snoop_cluster.sv
// Bench for msi_snoop_cluster: scoreboarded request/response checks covering
// hits, misses, upgrades, evictions, remote write-backs, errors and reset.
module tb_msi_snoop_cluster;

    localparam int NPROC  = 3;
    localparam int LINES  = 4;
    localparam int ADDR_W = 4;
    localparam int DW     = 4;
    localparam int PID_W  = 2;
    localparam int TAG_W  = 2;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [PID_W-1:0]  req_proc  = '0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic              resp_valid, resp_hit, resp_err;
    logic [DW-1:0]     resp_data;
    logic [1:0]        resp_prev, resp_new, bus_op, q_state;
    logic [7:0]        wb_count;
    logic [PID_W-1:0]  q_proc    = '0;
    logic [ADDR_W-1:0] q_addr    = '0;

    msi_snoop_cluster #(.NPROC(NPROC), .LINES(LINES), .ADDR_W(ADDR_W), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_proc(req_proc),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .resp_err(resp_err), .resp_prev(resp_prev), .resp_new(resp_new),
        .bus_op(bus_op), .wb_count(wb_count),
        .q_proc(q_proc), .q_addr(q_addr), .q_state(q_state)
    );

    typedef struct packed {
        logic [7:0]    id;
        logic [DW-1:0] data;
        logic          hit;
        logic          err;
        logic [1:0]    prev;
        logic [1:0]    nw;
        logic [1:0]    op;
        logic [7:0]    wb;
        logic [7:0]    lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   acc_cyc     = 0;

    always #5 clock = ~clock;

    // Free-running cycle counter used for latency measurement
    always @(posedge clock) cyc <= cyc + 1;

    // Set the status query inputs and let the combinational path settle
    task automatic probe(input logic [PID_W-1:0] p, input logic [ADDR_W-1:0] a);
        q_proc = p;
        q_addr = a;
        #1;
    endtask

    // Wait for the response strobe, pop the oldest expectation and compare
    task automatic collect_response();
        exp_t e;
        int   n, n_m, n_s, lat;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            for (int a = 0; a < 16; a++) begin
                n_m = 0;
                n_s = 0;
                for (int p = 0; p < NPROC; p++) begin
                    if (dut.tag_q[p][a % LINES] == TAG_W'(a / LINES)) begin
                        if (dut.st_q[p][a % LINES] == 2'd2) n_m++;
                        else if (dut.st_q[p][a % LINES] == 2'd1) n_s++;
                    end
                end
                if (n_m > 1 || (n_m == 1 && n_s > 0)) begin
                    miscompares++;
                    $display("FAIL coherence addr %0d got M=%0d S=%0d want M<=1 and no S beside M", a, n_m, n_s);
                end
            end
        end while (resp_valid !== 1'b1 && n < 12);
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout vec %0d got no resp_valid within %0d cycles want a response", sb[0].id, n);
            sb.delete();
        end else begin
            e   = sb.pop_front();
            lat = cyc - acc_cyc;
            vectors += 8;
            if (resp_data !== e.data) begin miscompares++; $display("FAIL resp_data vec %0d got %h want %h", e.id, resp_data, e.data); end
            if (resp_hit !== e.hit) begin miscompares++; $display("FAIL resp_hit vec %0d got %b want %b", e.id, resp_hit, e.hit); end
            if (resp_err !== e.err) begin miscompares++; $display("FAIL resp_err vec %0d got %b want %b", e.id, resp_err, e.err); end
            if (resp_prev !== e.prev) begin miscompares++; $display("FAIL resp_prev vec %0d got %0d want %0d", e.id, resp_prev, e.prev); end
            if (resp_new !== e.nw) begin miscompares++; $display("FAIL resp_new vec %0d got %0d want %0d", e.id, resp_new, e.nw); end
            if (bus_op !== e.op) begin miscompares++; $display("FAIL bus_op vec %0d got %0d want %0d", e.id, bus_op, e.op); end
            if (wb_count !== e.wb) begin miscompares++; $display("FAIL wb_count vec %0d got %0d want %0d", e.id, wb_count, e.wb); end
            if (lat != int'(e.lat)) begin miscompares++; $display("FAIL latency vec %0d got %0d want %0d", e.id, lat, e.lat); end
            @(negedge clock);
            vectors++;
            if ({resp_valid, req_ready} !== 2'b01 || resp_data !== e.data) begin
                miscompares++;
                $display("FAIL after_resp vec %0d got valid=%b ready=%b data=%h want valid=0 ready=1 data=%h",
                         e.id, resp_valid, req_ready, resp_data, e.data);
            end
        end
    endtask

    // Drive one request, queue its expected response, then collect it
    task automatic issue(input logic [7:0] id, input logic [PID_W-1:0] p, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] e_data, input logic e_hit, input logic e_err,
                         input logic [1:0] e_prev, input logic [1:0] e_new, input logic [1:0] e_op,
                         input logic [7:0] e_wb, input logic [7:0] e_lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        req_valid = 1'b1; req_proc = p; req_write = w; req_addr = a; req_wdata = wd;
        e.id = id; e.data = e_data; e.hit = e_hit; e.err = e_err; e.prev = e_prev;
        e.nw = e_new; e.op = e_op; e.wb = e_wb; e.lat = e_lat;
        sb.push_back(e);
        @(posedge clock);
        #1;
        acc_cyc   = cyc - 1;
        req_valid = 1'b0;
        req_proc  = PID_W'($urandom);
        req_write = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = DW'($urandom);
        collect_response();
    endtask

    task automatic test_reset();
        #1;
        vectors += 5;
        if ({resp_valid, req_ready, resp_hit, resp_err} !== 4'b0100) begin miscompares++; $display("FAIL reset_flags got %b want 0100", {resp_valid, req_ready, resp_hit, resp_err}); end
        if ({resp_data, resp_prev, resp_new, bus_op} !== 10'd0) begin miscompares++; $display("FAIL reset_fields got %h want 000", {resp_data, resp_prev, resp_new, bus_op}); end
        if (wb_count !== 8'd0) begin miscompares++; $display("FAIL reset_wb got %0d want 0", wb_count); end
        if (dut.mem_q[4'd5] !== 4'd5 || dut.mem_q[4'd15] !== 4'd15) begin miscompares++; $display("FAIL reset_mem got %h,%h want 5,f", dut.mem_q[4'd5], dut.mem_q[4'd15]); end
        probe(2'd0, 4'd5);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL reset_qstate got %0d want 0", q_state); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_read_miss_hit();
        issue(8'd1, 2'd0, 1'b0, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 8'd0, 8'd4);
        issue(8'd2, 2'd0, 1'b0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 8'd0, 8'd2);
        probe(2'd0, 4'd5);
        vectors++;
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL read_qstate_p0 got %0d want 1", q_state); end
    endtask

    task automatic test_write_invalidate();
        issue(8'd3, 2'd1, 1'b1, 4'd5, 4'hA, 4'hA, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 8'd0, 8'd4);
        vectors += 3;
        probe(2'd0, 4'd5);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL rdx_qstate_p0 got %0d want 0", q_state); end
        probe(2'd1, 4'd5);
        if (q_state !== 2'd2) begin miscompares++; $display("FAIL rdx_qstate_p1 got %0d want 2", q_state); end
        if (dut.mem_q[4'd5] !== 4'd5) begin miscompares++; $display("FAIL rdx_mem5 got %h want 5", dut.mem_q[4'd5]); end
    endtask

    task automatic test_remote_wb();
        issue(8'd4, 2'd2, 1'b0, 4'd5, 4'd0, 4'hA, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 8'd1, 8'd5);
        vectors += 3;
        probe(2'd1, 4'd5);
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL wb_qstate_p1 got %0d want 1", q_state); end
        probe(2'd2, 4'd5);
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL wb_qstate_p2 got %0d want 1", q_state); end
        if (dut.mem_q[4'd5] !== 4'hA) begin miscompares++; $display("FAIL wb_mem5 got %h want a", dut.mem_q[4'd5]); end
    endtask

    task automatic test_upgrade();
        issue(8'd5, 2'd2, 1'b1, 4'd5, 4'd3, 4'd3, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3, 8'd1, 8'd3);
        vectors += 2;
        probe(2'd1, 4'd5);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL upgr_qstate_p1 got %0d want 0", q_state); end
        probe(2'd2, 4'd5);
        if (q_state !== 2'd2) begin miscompares++; $display("FAIL upgr_qstate_p2 got %0d want 2", q_state); end
    endtask

    task automatic test_evict();
        issue(8'd6, 2'd2, 1'b0, 4'd9, 4'd0, 4'd9, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 8'd2, 8'd5);
        vectors += 3;
        if (dut.mem_q[4'd5] !== 4'd3) begin miscompares++; $display("FAIL evict_mem5 got %h want 3", dut.mem_q[4'd5]); end
        probe(2'd2, 4'd9);
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL evict_qstate_9 got %0d want 1", q_state); end
        probe(2'd2, 4'd5);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL evict_qstate_5 got %0d want 0", q_state); end
    endtask

    task automatic test_write_hit_m();
        issue(8'd7, 2'd0, 1'b1, 4'd6, 4'd7, 4'd7, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 8'd2, 8'd4);
        issue(8'd8, 2'd0, 1'b1, 4'd6, 4'hC, 4'hC, 1'b1, 1'b0, 2'd2, 2'd2, 2'd0, 8'd2, 8'd2);
        issue(8'd9, 2'd0, 1'b0, 4'd6, 4'd0, 4'hC, 1'b1, 1'b0, 2'd2, 2'd2, 2'd0, 8'd2, 8'd2);
    endtask

    task automatic test_back_to_back();
        issue(8'd10, 2'd1, 1'b1, 4'd6, 4'd1, 4'd1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 8'd3, 8'd5);
        vectors += 2;
        if (dut.mem_q[4'd6] !== 4'hC) begin miscompares++; $display("FAIL rdxwb_mem6 got %h want c", dut.mem_q[4'd6]); end
        probe(2'd0, 4'd6);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL rdxwb_qstate_p0 got %0d want 0", q_state); end
        issue(8'd11, 2'd0, 1'b1, 4'hA, 4'd5, 4'd5, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 8'd3, 8'd4);
        issue(8'd12, 2'd1, 1'b0, 4'hA, 4'd0, 4'd5, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 8'd5, 8'd6);
        vectors += 4;
        if (dut.mem_q[4'd6] !== 4'd1) begin miscompares++; $display("FAIL max_mem6 got %h want 1", dut.mem_q[4'd6]); end
        if (dut.mem_q[4'hA] !== 4'd5) begin miscompares++; $display("FAIL max_mema got %h want 5", dut.mem_q[4'hA]); end
        probe(2'd0, 4'hA);
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL max_qstate_p0 got %0d want 1", q_state); end
        probe(2'd1, 4'd6);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL max_qstate_p1 got %0d want 0", q_state); end
    endtask

    task automatic test_error();
        issue(8'd13, 2'd3, 1'b1, 4'hA, 4'hF, 4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'd5, 8'd2);
        vectors += 2;
        probe(2'd3, 4'hA);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL err_qstate_p3 got %0d want 0", q_state); end
        probe(2'd0, 4'hA);
        if (q_state !== 2'd1) begin miscompares++; $display("FAIL err_qstate_p0 got %0d want 1", q_state); end
    endtask

    task automatic test_reset_mid_snoop();
        exp_t e;
        int   n;
        n = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        req_valid = 1'b1; req_proc = 2'd0; req_write = 1'b0; req_addr = 4'd5;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        vectors += 5;
        if ({resp_valid, req_ready, resp_hit, resp_err} !== 4'b0100) begin miscompares++; $display("FAIL midrst_flags got %b want 0100", {resp_valid, req_ready, resp_hit, resp_err}); end
        if ({resp_data, resp_prev, resp_new, bus_op} !== 10'd0) begin miscompares++; $display("FAIL midrst_fields got %h want 000", {resp_data, resp_prev, resp_new, bus_op}); end
        if (wb_count !== 8'd0) begin miscompares++; $display("FAIL midrst_wb got %0d want 0", wb_count); end
        if (dut.mem_q[4'd5] !== 4'd5) begin miscompares++; $display("FAIL midrst_mem5 got %h want 5", dut.mem_q[4'd5]); end
        probe(2'd2, 4'd9);
        if (q_state !== 2'd0) begin miscompares++; $display("FAIL midrst_qstate got %0d want 0", q_state); end
        req_valid = 1'b1; req_proc = 2'd3; req_write = 1'b1; req_addr = 4'd5; req_wdata = 4'hF;
        e.id = 8'd14; e.data = 4'd0; e.hit = 1'b0; e.err = 1'b1; e.prev = 2'd0;
        e.nw = 2'd0; e.op = 2'd0; e.wb = 8'd0; e.lat = 8'd2;
        sb.push_back(e);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        acc_cyc   = cyc - 1;
        req_valid = 1'b0;
        collect_response();
        vectors++;
        if (dut.mem_q[4'd5] !== 4'd5) begin miscompares++; $display("FAIL midrst_err_mem5 got %h want 5", dut.mem_q[4'd5]); end
        issue(8'd15, 2'd0, 1'b0, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 8'd0, 8'd4);
    endtask

    // Sequence every scenario, then report
    initial begin
        #1 reset_n = 1'b0;
        test_reset();
        test_read_miss_hit();
        test_write_invalidate();
        test_remote_wb();
        test_upgrade();
        test_evict();
        test_write_hit_m();
        test_back_to_back();
        test_error();
        test_reset_mid_snoop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/msi_snoop_cluster.md
Name: msi_snoop_cluster

Overview:
- Parametrised successor of the fixed three-processor snooping-coherence demonstrator.
- Models NPROC private direct-mapped caches with LINES lines each, kept coherent with the MSI protocol over one shared snooping bus, backed by one shared memory.
- Requests are serialised through a single bus FSM with a valid/ready handshake.
- Intended to sit between switch-driven stimulus logic and seven-segment/LED status display logic on the board top level.

Parameters:
- NPROC, 3, number of processors/caches (2..8); PID_W = clog2(NPROC), minimum 1.
- LINES, 4, lines per cache, power of two; IDX_W = log2(LINES).
- ADDR_W, 4, word address width; memory depth = 2^ADDR_W; TAG_W = ADDR_W - IDX_W, must be at least 1.
- DW, 4, data word width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request; high only in IDLE.
- req_proc  in  PID_W  requesting processor.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DW  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_data  out  DW  read data, or written data for writes.
- resp_hit  out  1  local hit (state S or M with matching tag).
- resp_err  out  1  req_proc >= NPROC.
- resp_prev  out  2  requester line state before the access.
- resp_new  out  2  requester line state after the access.
- bus_op  out  2  bus transaction issued: 0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr.
- wb_count  out  8  count of memory write-backs; wraps.
- q_proc  in  PID_W  status query: processor.
- q_addr  in  ADDR_W  status query: address.
- q_state  out  2  combinational line state for (q_proc, q_addr); I if the tag mismatches or q_proc >= NPROC.

Behaviour:
- State encoding: I=0, S=1, M=2; value 3 is never stored.
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- Reset (asynchronous, any time, including mid-transaction):
  - transaction aborted, FSM to IDLE;
  - all lines I, tags 0, data 0;
  - memory word k = k[DW-1:0];
  - resp_valid=0, resp_data/resp_prev/resp_new/bus_op/resp_hit/resp_err=0, wb_count=0, req_ready=1.
- Accept on a clock edge with req_valid && req_ready; request fields are captured at that edge and later input changes are ignored.
- FSM states: IDLE, LOOKUP, EVICT, SNOOP, WB, FILL, RESP. Latency is counted from the accept edge (cycle 0) to the cycle resp_valid is high.
- resp_err request: IDLE->LOOKUP->RESP, latency 2, no state change, bus_op=0.
- Read hit (S/M), or write hit in M: IDLE->LOOKUP->RESP, latency 2, bus_op=0. A write stores wdata and the line stays M.
- Write hit in S: LOOKUP->SNOOP->RESP, latency 3, bus_op=BusUpgr. Every other cache with a matching S line -> I. Local line -> M with wdata.
- Miss (line I, or tag mismatch):
  - LOOKUP -> [EVICT] -> SNOOP -> [WB] -> FILL -> RESP; latency 4, +1 for EVICT, +1 for WB (maximum 6).
  - EVICT is entered only when the local victim is M with a different tag: memory[victim address] gets the victim data, wb_count +1.
  - SNOOP on a read miss issues BusRd; a remote M holder goes to WB, then becomes S.
  - SNOOP on a write miss issues BusRdX; a remote M holder goes to WB, then becomes I; remote S holders become I.
  - WB: memory gets the remote M data, wb_count +1.
  - FILL loads the line from memory, so the requester receives the written-back value.
  - Read miss: new state S. Write miss: new state M, data = wdata.
- Invariant: at most one M copy per address; M never coexists with S. A snoop that finds more than one M copy is a design error and is flagged by bench assertion.
- resp_* fields are held until the next response; resp_valid lasts exactly one cycle.
- req_ready goes high again in the cycle after RESP.

Test Plan:
- Reset, then P0 read 0x5 -> resp at cycle 4: data 5, hit 0, prev I, new S, bus_op 1, wb_count 0.
- P0 read 0x5 again -> cycle 2: data 5, hit 1, prev S, new S, bus_op 0.
- P1 write 0x5 data 0xA -> cycle 4: bus_op 2, P1 new M; q_state(P0,0x5)=I; memory[5] still 5.
- P2 read 0x5 -> cycle 5 (WB): data 0xA, P1 S, P2 S, wb_count 1, memory[5]=0xA.
- P2 write 0x5 data 0x3 -> cycle 3: bus_op 3, prev S, new M, q_state(P1,0x5)=I.
- P2 read 0x9 (same index 1) -> cycle 5 (EVICT): memory[5]=0x3, wb_count 2, data 9, new S.
- Assert reset_n low during SNOOP of a miss -> outputs immediately return to reset values and memory[5]=5; hold req_valid high with P3 request (NPROC=3) -> cycle 2, resp_err 1, no state change.
